cop1_issue_queue: RTL and testbench

Parametrised COP1 issue stage between the integer instruction stream and the FPU. Decodes MIPS COP1 instructions into 4-bit FPU op codes, buffers them in an in-order queue of depth `DEPTH`, and issues them to the FPU over a valid/ready handshake. A register scoreboard tracks FPRs with writes in flight, so RAW and WAW hazards stall issue. FPU exceptions flush the queue and latch a sticky flag. It replaces the single-cycle combinational COP1 decode of the previous generation.

---
 rtl/cop1_pkg.sv | 75 +++++++
 rtl/cop1_issue_queue_if.sv | 35 +++
 rtl/cop1_decoder.sv | 105 ++++++++++
 rtl/cop1_issue_queue.sv | 131 +++++++++++++
 tb/tb_cop1_issue_queue.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cop1_pkg.sv
// Shared COP1 issue-stage types: instruction field constants, FPU op codes
// and the queue entry carried from decode to issue.
package cop1_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned IDX_W   = 5;

   // Bit positions inside q_entry_t.src_mask
   localparam int unsigned SRC_FS = 0;
   localparam int unsigned SRC_FT = 1;

   localparam logic [5:0] OPC_COP1 = 6'h11;

   localparam logic [4:0] RS_MF  = 5'h00;
   localparam logic [4:0] RS_MT  = 5'h04;
   localparam logic [4:0] FMT_S  = 5'h10;
   localparam logic [4:0] FMT_W  = 5'h14;
   localparam logic [4:0] FMT_PS = 5'h16;

   localparam logic [5:0] FN_ADD      = 6'h00;
   localparam logic [5:0] FN_SUB      = 6'h01;
   localparam logic [5:0] FN_MUL      = 6'h02;
   localparam logic [5:0] FN_DIV      = 6'h03;
   localparam logic [5:0] FN_CVT_S_W  = 6'h20;
   localparam logic [5:0] FN_CVT_S_PU = 6'h20;
   localparam logic [5:0] FN_CVT_W_S  = 6'h24;
   localparam logic [5:0] FN_CVT_PS_S = 6'h26;
   localparam logic [5:0] FN_CVT_S_PL = 6'h28;

   typedef enum logic [3:0] {
      OP_IDLE   = 4'd0,
      OP_ADDS   = 4'd1,
      OP_ADDPS  = 4'd2,
      OP_SUBS   = 4'd3,
      OP_SUBPS  = 4'd4,
      OP_MULS   = 4'd5,
      OP_MULPS  = 4'd6,
      OP_DIVS   = 4'd7,
      OP_CVTPSS = 4'd8,
      OP_CVTSW  = 4'd9,
      OP_CVTWS  = 4'd10,
      OP_CVTSPL = 4'd11,
      OP_CVTSPU = 4'd12,
      OP_MFC1   = 4'd13,
      OP_MTC1   = 4'd14
   } fpu_op_t;

   // Operand shape of a decoded op
   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_BIN,
      CLS_UN,
      CLS_MF,
      CLS_MT
   } op_class_t;

   typedef enum logic [1:0] {
      DEC_OK,
      DEC_NOP,
      DEC_ILLEGAL
   } dec_status_t;

   typedef struct packed {
      fpu_op_t            op;
      logic [IDX_W-1:0]   fs;
      logic [IDX_W-1:0]   ft;
      logic [IDX_W-1:0]   fd;
      logic [DATA_W-1:0]  data;
      logic               has_dest;
      logic [IDX_W-1:0]   dest;
      logic [1:0]         src_mask;
   } q_entry_t;

endpackage

// File: rtl/cop1_issue_queue_if.sv
// Instruction-side and FPU-side handshake bundle of the COP1 issue queue.
interface cop1_issue_queue_if #(
   parameter int unsigned NUM_FPR = 32
) ();
   import cop1_pkg::*;

   localparam int unsigned REG_W = $clog2(NUM_FPR);

   logic                in_valid;
   logic                in_ready;
   logic [INSTR_W-1:0]  in_instr;
   logic [DATA_W-1:0]   in_gpr;

   logic                fpu_valid;
   logic                fpu_ready;
   logic [3:0]          fpu_instr;
   logic [REG_W-1:0]    fpu_fs;
   logic [REG_W-1:0]    fpu_ft;
   logic [REG_W-1:0]    fpu_fd;
   logic [DATA_W-1:0]   fpu_data;
   logic                fpu_done;
   logic [REG_W-1:0]    fpu_done_reg;
   logic                fpu_exception;

   modport slave (
      input  in_valid, in_instr, in_gpr, fpu_ready, fpu_done, fpu_done_reg, fpu_exception,
      output in_ready, fpu_valid, fpu_instr, fpu_fs, fpu_ft, fpu_fd, fpu_data
   );

   modport master (
      output in_valid, in_instr, in_gpr, fpu_ready, fpu_done, fpu_done_reg, fpu_exception,
      input  in_ready, fpu_valid, fpu_instr, fpu_fs, fpu_ft, fpu_fd, fpu_data
   );

endinterface

// File: rtl/cop1_decoder.sv
// Combinational COP1 decode: instruction word + GPR value -> queue entry and
// a legal / nop / illegal verdict.
module cop1_decoder
   import cop1_pkg::*;
#(
   parameter bit ENABLE_PS = 1'b1
) (
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [DATA_W-1:0]  i_gpr,
   output q_entry_t           o_entry,
   output dec_status_t        o_status
);

   logic [5:0]       w_opc;
   logic [4:0]       w_fmt;
   logic [IDX_W-1:0] w_ft;
   logic [IDX_W-1:0] w_fs;
   logic [IDX_W-1:0] w_fd;
   logic [5:0]       w_func;
   logic [10:0]      w_low11;
   fpu_op_t          w_op;
   op_class_t        w_cls;

   assign w_opc   = i_instr[31:26];
   assign w_fmt   = i_instr[25:21];
   assign w_ft    = i_instr[20:16];
   assign w_fs    = i_instr[15:11];
   assign w_fd    = i_instr[10:6];
   assign w_func  = i_instr[5:0];
   assign w_low11 = i_instr[10:0];

   // Op selection; anything not matched stays CLS_NONE
   always_comb begin
      w_op  = OP_IDLE;
      w_cls = CLS_NONE;
      if (w_opc == OPC_COP1) begin
         case (w_fmt)
            RS_MF: if (w_low11 == 11'd0) begin w_op = OP_MFC1; w_cls = CLS_MF; end
            RS_MT: if (w_low11 == 11'd0) begin w_op = OP_MTC1; w_cls = CLS_MT; end
            FMT_S: begin
               case (w_func)
                  FN_ADD:      begin w_op = OP_ADDS; w_cls = CLS_BIN; end
                  FN_SUB:      begin w_op = OP_SUBS; w_cls = CLS_BIN; end
                  FN_MUL:      begin w_op = OP_MULS; w_cls = CLS_BIN; end
                  FN_DIV:      begin w_op = OP_DIVS; w_cls = CLS_BIN; end
                  FN_CVT_PS_S: if (ENABLE_PS) begin w_op = OP_CVTPSS; w_cls = CLS_BIN; end
                  FN_CVT_W_S:  if (w_ft == '0) begin w_op = OP_CVTWS; w_cls = CLS_UN; end
                  default: ;
               endcase
            end
            FMT_PS: begin
               if (ENABLE_PS) begin
                  case (w_func)
                     FN_ADD:      begin w_op = OP_ADDPS; w_cls = CLS_BIN; end
                     FN_SUB:      begin w_op = OP_SUBPS; w_cls = CLS_BIN; end
                     FN_MUL:      begin w_op = OP_MULPS; w_cls = CLS_BIN; end
                     FN_CVT_S_PL: if (w_ft == '0) begin w_op = OP_CVTSPL; w_cls = CLS_UN; end
                     FN_CVT_S_PU: if (w_ft == '0) begin w_op = OP_CVTSPU; w_cls = CLS_UN; end
                     default: ;
                  endcase
               end
            end
            FMT_W: if (w_func == FN_CVT_S_W && w_ft == '0) begin w_op = OP_CVTSW; w_cls = CLS_UN; end
            default: ;
         endcase
      end
   end

   // Operand, destination and source-mask fill by operand shape
   always_comb begin
      o_entry    = '0;
      o_status   = (i_instr == '0) ? DEC_NOP : DEC_ILLEGAL;
      o_entry.op = w_op;
      case (w_cls)
         CLS_BIN: begin
            o_entry.fs       = w_fs;
            o_entry.ft       = w_ft;
            o_entry.fd       = w_fd;
            o_entry.has_dest = 1'b1;
            o_entry.dest     = w_fd;
            o_entry.src_mask = 2'b11;
         end
         CLS_UN: begin
            o_entry.fs       = w_fs;
            o_entry.fd       = w_fd;
            o_entry.has_dest = 1'b1;
            o_entry.dest     = w_fd;
            o_entry.src_mask[SRC_FS] = 1'b1;
         end
         CLS_MF: begin
            o_entry.fs               = w_fs;
            o_entry.src_mask[SRC_FS] = 1'b1;
         end
         CLS_MT: begin
            o_entry.fs       = w_fs;
            o_entry.data     = i_gpr;
            o_entry.has_dest = 1'b1;
            o_entry.dest     = w_fs;
         end
         default: ;
      endcase
      if (w_cls != CLS_NONE) o_status = DEC_OK;
   end

endmodule

// File: rtl/cop1_issue_queue.sv
// COP1 issue stage: decodes into an in-order FIFO, holds RAW/WAW hazards via a
// per-FPR busy scoreboard, and flushes on FPU exceptions.
module cop1_issue_queue
   import cop1_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned NUM_FPR   = 32,
   parameter bit          ENABLE_PS = 1'b1,
   localparam int unsigned REG_W    = $clog2(NUM_FPR),
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              cpu_clock,
   input  logic              cpu_reset,
   cop1_issue_queue_if.slave bus,
   output logic              illegal,
   output logic              exc_sticky,
   input  logic              exc_clear,
   output logic [CNT_W-1:0]  count,
   output logic              empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   q_entry_t          w_dec_entry;
   dec_status_t       w_dec_status;

   q_entry_t          r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [NUM_FPR-1:0] r_busy;
   logic              r_illegal;
   logic              r_exc_sticky;

   logic [PTR_W-1:0]  w_wr_nx, w_rd_nx;
   logic [CNT_W-1:0]  w_count_nx;
   logic [NUM_FPR-1:0] w_busy_nx, w_busy_eff, w_done_mask;
   logic              w_in_ready, w_accept, w_push, w_pop, w_exc, w_hazard, w_fpu_valid;
   q_entry_t          w_head;

   cop1_decoder #(.ENABLE_PS(ENABLE_PS)) u_decoder (
      .i_instr  (bus.in_instr),
      .i_gpr    (bus.in_gpr),
      .o_entry  (w_dec_entry),
      .o_status (w_dec_status)
   );

   assign w_in_ready = (r_count != CNT_W'(DEPTH)) && !r_exc_sticky && !cpu_reset;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_push     = w_accept && (w_dec_status == DEC_OK);
   assign w_exc      = bus.fpu_done && bus.fpu_exception;
   assign w_head     = r_mem[r_rd_ptr];

   // Completing register is treated as free in the same cycle (bypass)
   always_comb begin
      w_done_mask = '0;
      if (bus.fpu_done) w_done_mask[bus.fpu_done_reg] = 1'b1;
   end
   assign w_busy_eff = r_busy & ~w_done_mask;

   assign w_hazard = (w_head.src_mask[SRC_FS] && w_busy_eff[REG_W'(w_head.fs)])
                  || (w_head.src_mask[SRC_FT] && w_busy_eff[REG_W'(w_head.ft)])
                  || (w_head.has_dest         && w_busy_eff[REG_W'(w_head.dest)]);

   assign w_fpu_valid = (r_count != '0) && !w_hazard && !r_exc_sticky && !w_exc && !cpu_reset;
   assign w_pop       = w_fpu_valid && bus.fpu_ready;

   // Issue fields are driven only while valid so an idle port reads as zero
   always_comb begin
      bus.fpu_valid = w_fpu_valid;
      bus.fpu_instr = OP_IDLE;
      bus.fpu_fs    = '0;
      bus.fpu_ft    = '0;
      bus.fpu_fd    = '0;
      bus.fpu_data  = '0;
      if (w_fpu_valid) begin
         bus.fpu_instr = w_head.op;
         bus.fpu_fs    = REG_W'(w_head.fs);
         bus.fpu_ft    = REG_W'(w_head.ft);
         bus.fpu_fd    = REG_W'(w_head.fd);
         bus.fpu_data  = w_head.data;
      end
   end

   assign bus.in_ready = w_in_ready;

   // Next state: an exception drops queued work but keeps the scoreboard
   always_comb begin
      w_wr_nx    = r_wr_ptr;
      w_rd_nx    = r_rd_ptr;
      w_count_nx = r_count;
      w_busy_nx  = r_busy & ~w_done_mask;
      if (w_pop && w_head.has_dest) w_busy_nx[REG_W'(w_head.dest)] = 1'b1;
      if (w_exc) begin
         w_wr_nx    = '0;
         w_rd_nx    = '0;
         w_count_nx = '0;
      end else begin
         if (w_push) w_wr_nx = r_wr_ptr + PTR_W'(1);
         if (w_pop)  w_rd_nx = r_rd_ptr + PTR_W'(1);
         w_count_nx = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge cpu_clock) begin
      if (cpu_reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_busy       <= '0;
         r_illegal    <= 1'b0;
         r_exc_sticky <= 1'b0;
      end else begin
         r_wr_ptr     <= w_wr_nx;
         r_rd_ptr     <= w_rd_nx;
         r_count      <= w_count_nx;
         r_busy       <= w_busy_nx;
         r_illegal    <= w_accept && (w_dec_status == DEC_ILLEGAL);
         r_exc_sticky <= w_exc ? 1'b1 : (exc_clear ? 1'b0 : r_exc_sticky);
      end
   end

   always_ff @(posedge cpu_clock) begin
      if (w_push && !w_exc) r_mem[r_wr_ptr] <= w_dec_entry;
   end

   assign illegal    = r_illegal;
   assign exc_sticky = r_exc_sticky;
   assign count      = r_count;
   assign empty      = (r_count == '0);

endmodule

// File: tb/tb_cop1_issue_queue.sv
// Scoreboard bench for cop1_issue_queue: expected issues are queued at push
// time and matched by an independent monitor on every FPU handshake.
module tb_cop1_issue_queue;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cop1_issue_queue_if #(.NUM_FPR(32)) u_if ();
   cop1_issue_queue_if #(.NUM_FPR(32)) u_if2 ();

   logic       illegal, exc_sticky, exc_clear, empty;
   logic [2:0] count;
   logic       illegal2, exc_sticky2, exc_clear2, empty2;
   logic [2:0] count2;

   cop1_issue_queue #(.DEPTH(4), .NUM_FPR(32), .ENABLE_PS(1'b1)) u_dut (
      .cpu_clock  (clk),
      .cpu_reset  (rst),
      .bus        (u_if),
      .illegal    (illegal),
      .exc_sticky (exc_sticky),
      .exc_clear  (exc_clear),
      .count      (count),
      .empty      (empty)
   );

   cop1_issue_queue #(.DEPTH(4), .NUM_FPR(32), .ENABLE_PS(1'b0)) u_dut_nops (
      .cpu_clock  (clk),
      .cpu_reset  (rst),
      .bus        (u_if2),
      .illegal    (illegal2),
      .exc_sticky (exc_sticky2),
      .exc_clear  (exc_clear2),
      .count      (count2),
      .empty      (empty2)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  fs;
      logic [4:0]  ft;
      logic [4:0]  fd;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_got, mon_exp;
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [31:0] enc(input logic [4:0] fmt, input logic [4:0] ft,
                                       input logic [4:0] fs, input logic [4:0] fd,
                                       input logic [5:0] fn);
      return {6'h11, fmt, ft, fs, fd, fn};
   endfunction

   function automatic exp_t mk(input int op, input int fs, input int ft, input int fd,
                               input logic [31:0] data);
      exp_t e;
      e.op = 4'(op); e.fs = 5'(fs); e.ft = 5'(ft); e.fd = 5'(fd); e.data = data;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] gpr);
      int n;
      n = 0;
      u_if.in_valid = 1'b1;
      u_if.in_instr = instr;
      u_if.in_gpr   = gpr;
      while (!u_if.in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         n_total++;
         $display("FAIL push_timeout: in_ready stayed low for instr 0x%08h", instr);
      end
      step();
      u_if.in_valid = 1'b0;
   endtask

   // Monitor: every handshake must match the oldest expected issue
   always @(negedge clk) begin
      if (!rst && u_if.fpu_valid && u_if.fpu_ready) begin
         mon_got = {u_if.fpu_instr, u_if.fpu_fs, u_if.fpu_ft, u_if.fpu_fd, u_if.fpu_data};
         if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL issue_unexpected: got 0x%0h expected no issue", mon_got);
         end else begin
            mon_exp = sb_q.pop_front();
            chk("issue", 64'(mon_got), 64'(mon_exp));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      exc_clear = 1'b0;  exc_clear2 = 1'b0;
      u_if.in_valid = 1'b0;  u_if.in_instr = '0;  u_if.in_gpr = '0;
      u_if.fpu_ready = 1'b1; u_if.fpu_done = 1'b0; u_if.fpu_done_reg = '0; u_if.fpu_exception = 1'b0;
      u_if2.in_valid = 1'b0; u_if2.in_instr = '0; u_if2.in_gpr = '0;
      u_if2.fpu_ready = 1'b1; u_if2.fpu_done = 1'b0; u_if2.fpu_done_reg = '0; u_if2.fpu_exception = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("in_ready_in_reset", 64'(u_if.in_ready), 64'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_fpu_valid", 64'(u_if.fpu_valid), 64'd0);
      chk("rst_illegal",   64'(illegal),        64'd0);
      chk("rst_exc",       64'(exc_sticky),     64'd0);
      chk("rst_count",     64'(count),          64'd0);
      chk("rst_empty",     64'(empty),          64'd1);
      chk("rst_fields",    64'({u_if.fpu_instr, u_if.fpu_fs, u_if.fpu_ft, u_if.fpu_fd, u_if.fpu_data}), 64'd0);
      chk("rst_in_ready",  64'(u_if.in_ready),  64'd1);
      step();

      // add.s f3,f1,f2 issues the cycle after acceptance
      sb_q.push_back(mk(1, 1, 2, 3, 32'h0));
      push(32'h460208C0, 32'h0);
      @(negedge clk);
      chk("latency_valid", 64'(u_if.fpu_valid), 64'd1);
      step();

      // mul.s f4,f3,f3 waits on f3, then issues in the cycle its completion arrives
      sb_q.push_back(mk(5, 3, 3, 4, 32'h0));
      push(enc(5'h10, 5'd3, 5'd3, 5'd4, 6'h02), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("raw_stall", 64'(u_if.fpu_valid), 64'd0);
         step();
      end
      u_if.fpu_done = 1'b1; u_if.fpu_done_reg = 5'd3;
      @(negedge clk);
      chk("bypass_valid", 64'(u_if.fpu_valid), 64'd1);
      chk("bypass_op",    64'(u_if.fpu_instr), 64'd5);
      step();
      u_if.fpu_done_reg = 5'd4;
      step();
      u_if.fpu_done = 1'b0;

      // fill the queue with the FPU stalled, then drain back-to-back
      u_if.fpu_ready = 1'b0;
      sb_q.push_back(mk(1, 1, 2, 10, 32'h0));
      sb_q.push_back(mk(3, 1, 2, 11, 32'h0));
      sb_q.push_back(mk(5, 1, 2, 12, 32'h0));
      sb_q.push_back(mk(7, 1, 2, 13, 32'h0));
      push(enc(5'h10, 5'd2, 5'd1, 5'd10, 6'h00), 32'h0);
      push(enc(5'h10, 5'd2, 5'd1, 5'd11, 6'h01), 32'h0);
      push(enc(5'h10, 5'd2, 5'd1, 5'd12, 6'h02), 32'h0);
      push(enc(5'h10, 5'd2, 5'd1, 5'd13, 6'h03), 32'h0);
      @(negedge clk);
      chk("full_count",    64'(count),          64'd4);
      chk("full_in_ready", 64'(u_if.in_ready),  64'd0);
      chk("full_head_op",  64'(u_if.fpu_instr), 64'd1);
      step();
      u_if.in_valid = 1'b1;
      u_if.in_instr = enc(5'h10, 5'd2, 5'd1, 5'd9, 6'h00);
      step();
      step();
      u_if.in_valid = 1'b0;
      @(negedge clk);
      chk("full_reject", 64'(count), 64'd4);
      step();
      u_if.fpu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_valid", 64'(u_if.fpu_valid), 64'd1);
         step();
      end
      @(negedge clk);
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_empty", 64'(empty), 64'd1);
      step();

      // mtc1 r5 -> f7 carries GPR data; mfc1 from f7 then waits for it
      sb_q.push_back(mk(14, 7, 0, 0, 32'h3F800000));
      push(32'h44853800, 32'h3F800000);
      step();
      sb_q.push_back(mk(13, 7, 0, 0, 32'h0));
      push(32'h44023800, 32'h12345678);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mtc1_busy_stall", 64'(u_if.fpu_valid), 64'd0);
         step();
      end
      u_if.fpu_done = 1'b1; u_if.fpu_done_reg = 5'd7;
      @(negedge clk);
      chk("mfc1_valid", 64'(u_if.fpu_valid), 64'd1);
      step();
      u_if.fpu_done = 1'b0;

      // nop word and div.ps
      push(32'h00000000, 32'h0);
      @(negedge clk);
      chk("nop_illegal", 64'(illegal), 64'd0);
      chk("nop_count",   64'(count),   64'd0);
      step();
      push(32'h46C208C3, 32'h0);
      @(negedge clk);
      chk("divps_illegal", 64'(illegal), 64'd1);
      chk("divps_count",   64'(count),   64'd0);
      step();
      @(negedge clk);
      chk("illegal_pulse_end", 64'(illegal), 64'd0);
      step();

      // paired-single and conversion decode
      sb_q.push_back(mk(2, 21, 22, 20, 32'h0));
      push(enc(5'h16, 5'd22, 5'd21, 5'd20, 6'h00), 32'h0);
      sb_q.push_back(mk(9, 6, 0, 5, 32'h0));
      push(enc(5'h14, 5'd0, 5'd6, 5'd5, 6'h20), 32'h0);
      sb_q.push_back(mk(8, 1, 2, 8, 32'h0));
      push(enc(5'h10, 5'd2, 5'd1, 5'd8, 6'h26), 32'h0);
      sb_q.push_back(mk(10, 1, 0, 9, 32'h0));
      push(enc(5'h10, 5'd0, 5'd1, 5'd9, 6'h24), 32'h0);
      sb_q.push_back(mk(11, 25, 0, 24, 32'h0));
      push(enc(5'h16, 5'd0, 5'd25, 5'd24, 6'h28), 32'h0);
      sb_q.push_back(mk(12, 27, 0, 26, 32'h0));
      push(enc(5'h16, 5'd0, 5'd27, 5'd26, 6'h20), 32'h0);
      repeat (3) step();
      @(negedge clk);
      chk("cvt_drain_count", 64'(count), 64'd0);
      step();

      // add.ps is illegal when paired-single support is off
      u_if2.in_valid = 1'b1;
      u_if2.in_instr = enc(5'h16, 5'd22, 5'd21, 5'd20, 6'h00);
      step();
      u_if2.in_valid = 1'b0;
      @(negedge clk);
      chk("nops_addps_illegal", 64'(illegal2), 64'd1);
      chk("nops_addps_count",   64'(count2),   64'd0);
      step();

      // exception with three ops queued
      u_if.fpu_ready = 1'b0;
      push(enc(5'h10, 5'd2, 5'd1, 5'd14, 6'h00), 32'h0);
      push(enc(5'h10, 5'd2, 5'd1, 5'd15, 6'h00), 32'h0);
      push(enc(5'h10, 5'd2, 5'd1, 5'd16, 6'h00), 32'h0);
      @(negedge clk);
      chk("exc_pre_count", 64'(count),          64'd3);
      chk("exc_pre_valid", 64'(u_if.fpu_valid), 64'd1);
      step();
      u_if.fpu_done = 1'b1; u_if.fpu_exception = 1'b1; u_if.fpu_done_reg = 5'd0;
      @(negedge clk);
      chk("exc_retract", 64'(u_if.fpu_valid), 64'd0);
      step();
      u_if.fpu_done = 1'b0; u_if.fpu_exception = 1'b0;
      @(negedge clk);
      chk("exc_flush_count", 64'(count),         64'd0);
      chk("exc_sticky_set",  64'(exc_sticky),    64'd1);
      chk("exc_in_ready",    64'(u_if.in_ready), 64'd0);
      step();
      u_if.in_valid = 1'b1;
      u_if.in_instr = enc(5'h10, 5'd2, 5'd1, 5'd18, 6'h00);
      step();
      step();
      u_if.in_valid = 1'b0;
      @(negedge clk);
      chk("exc_blocks_accept", 64'(count), 64'd0);
      step();
      exc_clear = 1'b1; u_if.fpu_done = 1'b1; u_if.fpu_exception = 1'b1;
      step();
      exc_clear = 1'b0; u_if.fpu_done = 1'b0; u_if.fpu_exception = 1'b0;
      @(negedge clk);
      chk("exc_beats_clear", 64'(exc_sticky), 64'd1);
      step();
      exc_clear = 1'b1;
      step();
      exc_clear = 1'b0;
      @(negedge clk);
      chk("exc_cleared",       64'(exc_sticky),    64'd0);
      chk("exc_clear_ready",   64'(u_if.in_ready), 64'd1);
      step();
      u_if.fpu_ready = 1'b1;
      sb_q.push_back(mk(1, 1, 2, 17, 32'h0));
      push(enc(5'h10, 5'd2, 5'd1, 5'd17, 6'h00), 32'h0);
      repeat (3) step();
      @(negedge clk);
      chk("sb_drain",    64'(sb_q.size()), 64'd0);
      chk("final_count", 64'(count),       64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
